mii_net_fcs_engine: RTL and testbench
=====================================

# mii_net_fcs_engine

Streaming 802.3 frame-check-sequence engine. It is the parametrised successor of the byte-wide CRC32 calculator, supporting 4-bit (MII nibble) and 8-bit (byte) datapaths. It has two build-time modes: TX appends the 4-octet FCS after the last data beat, and RX checks the received FCS and reports frame status. It sits between the MAC framer/deframer and the MII PHY-side logic, with a valid/ready handshake on both sides.

## Interface
- `DATA_W`, 8: beat width; legal values are 4 and 8 only. Any other value is an elaboration error.
- `MODE_TX`, 1: 1 = append FCS (TX); 0 = check FCS (RX).
- `i_clk` input 1: clock.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_d` input DATA_W: input beat. Octets arrive in wire order; for DATA_W=4 the low nibble comes first.
- `i_valid` input 1: input beat valid.
- `i_last` input 1: final beat of the frame. In RX mode this is the final FCS beat.
- `o_ready` output 1: input beat accepted when `i_valid && o_ready`.
- `o_d` output DATA_W: output beat.
- `o_valid` output 1: output beat valid.
- `o_last` output 1: final output beat of the frame.
- `i_ready` input 1: downstream accepts the output beat when `o_valid && i_ready`.
- `o_stat_valid` output 1: RX only; one-cycle frame-status strobe.
- `o_fcs_ok` output 1: RX only; residue matched. Valid with `o_stat_valid`.
- `o_runt` output 1: RX only; the frame was shorter than `32/DATA_W + 1` beats. Valid with `o_stat_valid`.
- `o_err_cnt` output 16: RX FCS-error counter (see Configuration).

## Operation
- CRC is reflected CRC-32, polynomial 0xEDB88320, computed LSB-first within each beat.
  - Register init is 0xFFFFFFFF at frame start.
  - Per bit: `fb = crc[0] ^ d[i]`, then `crc = (crc >> 1) ^ (fb ? 0xEDB88320 : 0)`, for i = 0 .. DATA_W-1.
- Frame start is the first accepted beat after reset or after the previous frame's `i_last`. The CRC register is re-initialised on that beat; there is no separate init port.
- Output is a single registered stage. The output register loads when it is empty or being drained: `load = ~o_valid | i_ready`.
- TX FSM has states DATA and FCS.
  - DATA: `o_ready = load`. Each accepted beat passes to `o_d` unchanged, with `o_last = 0`, and updates the CRC.
  - On accepting `i_last`: latch `fcs = ~crc_next`, clear beat counter `k`, go to FCS.
  - FCS: `o_ready = 0`. Emit NB = 32/DATA_W beats, one per load. Each beat is `fcs[DATA_W-1:0]`, then `fcs` shifts right by DATA_W.
  - `o_last = 1` on beat NB-1; on its load, return to DATA.
- RX FSM has a single state.
  - `o_ready = load`. Beats, including the FCS beats, pass through unchanged; `o_last = i_last`.
  - The CRC runs over all beats. A beat counter saturates at NB+1.
  - On accepting `i_last`, the next cycle asserts `o_stat_valid = 1` with:
    - `o_fcs_ok = (crc_next == 0xDEBB20E3) && !runt`.
    - `o_runt = (count < NB+1)`.
- A 1-beat frame (first beat also `i_last`) is legal. In TX it yields 1 data beat plus NB FCS beats.

## Timing
- Reset values:
  - `o_valid = 0`, `o_last = 0`, `o_d = 0`.
  - `o_stat_valid = 0`, `o_fcs_ok = 0`, `o_runt = 0`.
  - `o_err_cnt = 0`, CRC = 0xFFFFFFFF, FSM = DATA.
  - `o_ready` is 1 once reset is released.
- Latency: an accepted input beat appears on `o_d` the next cycle. The first TX FCS beat appears the cycle after the last data beat is loaded, if `i_ready` was high.
- Throughput is 1 beat/cycle with `i_ready` held high. TX stalls input for exactly NB cycles per frame.
- Holding rules: `o_d` and `o_last` are stable while `o_valid && !i_ready`. `o_ready` combinationally follows `i_ready` only through `load`.
- `o_stat_valid` is high for exactly one cycle, the cycle after `i_last` is accepted. It coincides with `o_valid && o_last`.
- Asynchronous reset mid-frame or mid-FCS: the frame is abandoned, no status strobe is produced, and the next accepted beat starts a new frame.

## Configuration
- `MII_NET_FCS_ERRCNT_EN` defined:
  - In RX mode, `o_err_cnt` increments on every `o_stat_valid` with `o_fcs_ok = 0`, including runts.
  - The counter saturates at 0xFFFF and is cleared only by `i_reset`.
- Not defined, or in TX mode: `o_err_cnt` is constant 0 and no counter flops are generated.

## Test plan
- TX, DATA_W=8: send "123456789" (0x31..0x39, `i_ready` = 1) -> output is the 9 data bytes then 0x26, 0x39, 0xF4, 0xCB, `o_last` on 0xCB, 13 output beats, `o_ready` low for 4 cycles.
- TX, DATA_W=4: same frame as nibbles, low nibble first -> the FCS nibbles are 6, 2, 9, 3, 4, F, B, C, with `o_last` on C.
- RX, DATA_W=8: send the 13-byte good frame -> one `o_stat_valid` pulse with `o_fcs_ok = 1`, `o_runt = 0`. Flip bit 0 of byte 3 -> `o_fcs_ok = 0`, and `o_err_cnt` = 1 with the macro defined (0 without).
- Backpressure: toggle `i_ready` pseudo-randomly during the TX frame -> output beats are identical to the unstalled run, no beat is lost or duplicated, and `o_d` is stable while stalled.
- RX runt: a 3-byte frame with `i_last` -> `o_runt = 1`, `o_fcs_ok = 0`. Then 0xFFFF+2 bad frames -> `o_err_cnt` holds at 0xFFFF.
- Reset mid-FCS: assert `i_reset` while the TX FCS beat 2 is pending -> next cycle `o_valid = 0`. A new "123456789" frame then yields the correct 0x26, 0x39, 0xF4, 0xCB.

Source files
------------

// File: rtl/mii_net_fcs_engine.sv
// Streaming 802.3 CRC-32 FCS engine, 4- or 8-bit beats: TX appends FCS, RX checks residue.
// One registered output stage. Optional RX FCS-error counter: `define MII_NET_FCS_ERRCNT_EN.
module mii_net_fcs_engine #(
  parameter int DATA_W  = 8,
  parameter bit MODE_TX = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_d,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_d,
  output logic              o_valid,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_stat_valid,
  output logic              o_fcs_ok,
  output logic              o_runt,
  output logic [15:0]       o_err_cnt
);
  localparam int          NB      = 32 / DATA_W;
  localparam logic [3:0]  NB_L    = 4'(NB);
  localparam logic [3:0]  K_LAST  = 4'(NB - 1);
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  if (DATA_W != 4 && DATA_W != 8) begin : g_bad_width
    $error("mii_net_fcs_engine: DATA_W must be 4 or 8");
  end

  typedef enum logic {S_DATA = 1'b0, S_FCS = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] crc, crc_next, fcs;
  logic [3:0]  k, count;
  logic        load, acc;

  assign load = ~o_valid | i_ready;
  assign acc  = i_valid & o_ready;

  // LSB-first reflected CRC over the current input beat
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < DATA_W; i++) begin
      crc_next = (crc_next >> 1) ^ ({32{crc_next[0] ^ i_d[i]}} & POLY);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_DATA;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DATA:  if (MODE_TX && acc && i_last) state_nxt = S_FCS;
      S_FCS:   if (load && k == K_LAST) state_nxt = S_DATA;
      default: state_nxt = S_DATA;
    endcase
  end

  always_comb begin
    o_ready = (state == S_DATA) & load;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_d          <= '0;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      crc          <= 32'hFFFFFFFF;
      fcs          <= '0;
      k            <= '0;
      count        <= '0;
      o_stat_valid <= 1'b0;
      o_fcs_ok     <= 1'b0;
      o_runt       <= 1'b0;
    end else begin
      o_stat_valid <= 1'b0;
      if (state == S_FCS) begin
        if (load) begin
          o_d     <= fcs[DATA_W-1:0];
          o_valid <= 1'b1;
          o_last  <= (k == K_LAST);
          fcs     <= fcs >> DATA_W;
          k       <= k + 4'd1;
        end
      end else if (acc) begin
        o_d     <= i_d;
        o_valid <= 1'b1;
        o_last  <= MODE_TX ? 1'b0 : i_last;
        // re-arm on the last beat so the next accepted beat starts a fresh frame
        crc     <= i_last ? 32'hFFFFFFFF : crc_next;
        if (i_last)                 count <= '0;
        else if (count != NB_L + 4'd1) count <= count + 4'd1;
        if (i_last) begin
          if (MODE_TX) begin
            fcs <= ~crc_next;
            k   <= '0;
          end else begin
            // count holds the beats before this one, so a runt has count < NB
            o_stat_valid <= 1'b1;
            o_fcs_ok     <= (crc_next == RESIDUE) && (count >= NB_L);
            o_runt       <= (count < NB_L);
          end
        end
      end else if (load) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef MII_NET_FCS_ERRCNT_EN
  if (!MODE_TX) begin : g_err
    logic [15:0] err_cnt;
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) err_cnt <= '0;
      else if (o_stat_valid && !o_fcs_ok && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
    assign o_err_cnt = err_cnt;
  end else begin : g_no_err
    assign o_err_cnt = 16'h0000;
  end
`else
  assign o_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mii_net_fcs_engine.sv
// Scoreboard bench: TX8, TX4 and RX8 instances against a byte-level CRC-32 reference model.
module tb_mii_net_fcs_engine;
  logic clk, rst, bp;
  int   checks, errors;

  logic [7:0] t8_d, t8_od;  logic t8_v, t8_l, t8_ordy, t8_ov, t8_ol, t8_ir, t8_sv, t8_ok, t8_rn;
  logic [3:0] t4_d, t4_od;  logic t4_v, t4_l, t4_ordy, t4_ov, t4_ol, t4_ir, t4_sv, t4_ok, t4_rn;
  logic [7:0] rx_d, rx_od;  logic rx_v, rx_l, rx_ordy, rx_ov, rx_ol, rx_ir, rx_sv, rx_ok, rx_rn;
  logic [15:0] t8_err, t4_err, rx_err, err_exp;

  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] exprx_q[$];
  logic [1:0] stat_q[$];
  int t8_stall, t4_stall;

  mii_net_fcs_engine #(.DATA_W(8), .MODE_TX(1'b1)) u_tx8 (
    .i_clk(clk), .i_reset(rst), .i_d(t8_d), .i_valid(t8_v), .i_last(t8_l), .o_ready(t8_ordy),
    .o_d(t8_od), .o_valid(t8_ov), .o_last(t8_ol), .i_ready(t8_ir), .o_stat_valid(t8_sv),
    .o_fcs_ok(t8_ok), .o_runt(t8_rn), .o_err_cnt(t8_err));
  mii_net_fcs_engine #(.DATA_W(4), .MODE_TX(1'b1)) u_tx4 (
    .i_clk(clk), .i_reset(rst), .i_d(t4_d), .i_valid(t4_v), .i_last(t4_l), .o_ready(t4_ordy),
    .o_d(t4_od), .o_valid(t4_ov), .o_last(t4_ol), .i_ready(t4_ir), .o_stat_valid(t4_sv),
    .o_fcs_ok(t4_ok), .o_runt(t4_rn), .o_err_cnt(t4_err));
  mii_net_fcs_engine #(.DATA_W(8), .MODE_TX(1'b0)) u_rx8 (
    .i_clk(clk), .i_reset(rst), .i_d(rx_d), .i_valid(rx_v), .i_last(rx_l), .o_ready(rx_ordy),
    .o_d(rx_od), .o_valid(rx_ov), .o_last(rx_ol), .i_ready(rx_ir), .o_stat_valid(rx_sv),
    .o_fcs_ok(rx_ok), .o_runt(rx_rn), .o_err_cnt(rx_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return c;
  endfunction

  function automatic logic rdy_of(input int id);
    return (id == 0) ? t8_ordy : (id == 1) ? t4_ordy : rx_ordy;
  endfunction

  // present one beat and hold it until accepted (bounded)
  task automatic drive(input int id, input logic [7:0] d, input logic last);
    int n;
    case (id)
      0:       begin t8_d = d;      t8_v = 1'b1; t8_l = last; end
      1:       begin t4_d = d[3:0]; t4_v = 1'b1; t4_l = last; end
      default: begin rx_d = d;      rx_v = 1'b1; rx_l = last; end
    endcase
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy_of(id) && n < 200);
    if (n >= 200) chk("accept_timeout", 32'(id), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    t8_v = 1'b0; t4_v = 1'b0; rx_v = 1'b0;
  endtask

  task automatic tx_drive(input int id, input logic [7:0] fr[$]);
    for (int i = 0; i < fr.size(); i++) begin
      if (id == 0) drive(0, fr[i], i == fr.size() - 1);
      else begin
        drive(1, {4'h0, fr[i][3:0]}, 1'b0);
        drive(1, {4'h0, fr[i][7:4]}, i == fr.size() - 1);
      end
    end
  endtask

  task automatic tx_push_model(input int id, input logic [7:0] fr[$]);
    logic [31:0] c, f;
    c = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      c = crc_upd(c, fr[i]);
      if (id == 0) exp8_q.push_back({1'b0, fr[i]});
      else begin exp4_q.push_back({1'b0, fr[i][3:0]}); exp4_q.push_back({1'b0, fr[i][7:4]}); end
    end
    f = ~c;
    if (id == 0) for (int i = 0; i < 4; i++) exp8_q.push_back({i == 3, f[8*i +: 8]});
    else         for (int i = 0; i < 8; i++) exp4_q.push_back({i == 7, f[4*i +: 4]});
  endtask

  function automatic logic [1:0] rx_model(input logic [7:0] fr[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    return {(c == 32'hDEBB20E3) && (fr.size() >= 5), fr.size() < 5};
  endfunction

  task automatic rx_send(input logic [7:0] fr[$], input logic ok, input logic runt);
    foreach (fr[i]) exprx_q.push_back({i == fr.size() - 1, fr[i]});
    stat_q.push_back({ok, runt});
`ifdef MII_NET_FCS_ERRCNT_EN
    if (!ok && err_exp != 16'hFFFF) err_exp++;
`endif
    foreach (fr[i]) drive(2, fr[i], i == fr.size() - 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp8_q.size() + exp4_q.size() + exprx_q.size() + stat_q.size()) != 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'(exp8_q.size() + exp4_q.size() + exprx_q.size()), 0);
    repeat (2) @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    t8_ir = (bp && !rst) ? 1'($urandom_range(0, 1)) : 1'b1;
    t4_ir = (bp && !rst) ? 1'($urandom_range(0, 1)) : 1'b1;
    rx_ir = (bp && !rst) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && !t8_ordy) t8_stall++;
    if (!rst && !t4_ordy) t4_stall++;
  end

  // monitor: hold checks on stalls, pop-and-compare on every transfer
  logic       h8_v, h4_v, hr_v;
  logic [8:0] h8, hr;
  logic [4:0] h4;
  always @(negedge clk) begin
    if (rst) begin
      h8_v = 1'b0; h4_v = 1'b0; hr_v = 1'b0;
    end else begin
      if (h8_v) chk("tx8_hold", {t8_ol, t8_od}, h8);
      if (h4_v) chk("tx4_hold", {t4_ol, t4_od}, h4);
      if (hr_v) chk("rx_hold",  {rx_ol, rx_od}, hr);
      if (t8_ov && t8_ir) begin
        if (exp8_q.size() == 0) chk("tx8_extra_beat", {t8_ol, t8_od}, 32'hFFFF_FFFF);
        else chk("tx8_beat", {t8_ol, t8_od}, exp8_q.pop_front());
      end
      if (t4_ov && t4_ir) begin
        if (exp4_q.size() == 0) chk("tx4_extra_beat", {t4_ol, t4_od}, 32'hFFFF_FFFF);
        else chk("tx4_beat", {t4_ol, t4_od}, exp4_q.pop_front());
      end
      if (rx_ov && rx_ir) begin
        if (exprx_q.size() == 0) chk("rx_extra_beat", {rx_ol, rx_od}, 32'hFFFF_FFFF);
        else chk("rx_beat", {rx_ol, rx_od}, exprx_q.pop_front());
      end
      if (rx_sv) begin
        chk("rx_stat_align", {rx_ov, rx_ol}, 2'b11);
        if (stat_q.size() == 0) chk("rx_extra_stat", {rx_ok, rx_rn}, 32'hFFFF_FFFF);
        else chk("rx_stat", {rx_ok, rx_rn}, stat_q.pop_front());
      end
      if (t8_sv || t4_sv) chk("tx_stat_strobe", {t8_sv, t4_sv}, 0);
      h8_v = t8_ov && !t8_ir; h8 = {t8_ol, t8_od};
      h4_v = t4_ov && !t4_ir; h4 = {t4_ol, t4_od};
      hr_v = rx_ov && !rx_ir; hr = {rx_ol, rx_od};
    end
  end

  logic [7:0] msg[$], fr[$];
  logic [3:0] fcs4[$];
  logic [7:0] fcs8[$];
  logic [1:0] st;

  initial begin
    checks = 0; errors = 0; bp = 1'b0; err_exp = '0;
    t8_d = '0; t8_v = 1'b0; t8_l = 1'b0; t8_ir = 1'b1;
    t4_d = '0; t4_v = 1'b0; t4_l = 1'b0; t4_ir = 1'b1;
    rx_d = '0; rx_v = 1'b0; rx_l = 1'b0; rx_ir = 1'b1;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcs8 = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    fcs4 = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx8_out", {t8_ov, t8_ol, t8_od, t8_sv, t8_ok, t8_rn}, 0);
    chk("rst_tx4_out", {t4_ov, t4_ol, t4_od, t4_sv, t4_ok, t4_rn}, 0);
    chk("rst_rx_out",  {rx_ov, rx_ol, rx_od, rx_sv, rx_ok, rx_rn}, 0);
    chk("rst_err_cnt", {t8_err, rx_err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {t8_ordy, t4_ordy, rx_ordy}, 3'b111);
    @(posedge clk); #1;

    // known vector, unstalled
    t8_stall = 0;
    foreach (msg[i]) exp8_q.push_back({1'b0, msg[i]});
    foreach (fcs8[i]) exp8_q.push_back({i == 3, fcs8[i]});
    tx_drive(0, msg);
    wait_drain();
    chk("tx8_stall_cycles", t8_stall, 4);

    t4_stall = 0;
    foreach (msg[i]) begin exp4_q.push_back({1'b0, msg[i][3:0]}); exp4_q.push_back({1'b0, msg[i][7:4]}); end
    foreach (fcs4[i]) exp4_q.push_back({i == 7, fcs4[i]});
    tx_drive(1, msg);
    wait_drain();
    chk("tx4_stall_cycles", t4_stall, 8);

    // backpressure: known vector again plus random frames, including 1-beat frames
    bp = 1'b1;
    foreach (msg[i]) exp8_q.push_back({1'b0, msg[i]});
    foreach (fcs8[i]) exp8_q.push_back({i == 3, fcs8[i]});
    tx_drive(0, msg);
    for (int f = 0; f < 8; f++) begin
      fr = {};
      repeat ((f < 2) ? 1 : $urandom_range(1, 16)) fr.push_back(8'($urandom));
      tx_push_model(0, fr); tx_drive(0, fr);
      tx_push_model(1, fr); tx_drive(1, fr);
    end
    wait_drain();
    bp = 1'b0;

    // RX: good frame, single-bit error, runt
    fr = msg; foreach (fcs8[i]) fr.push_back(fcs8[i]);
    rx_send(fr, 1'b1, 1'b0);
    fr[3] = fr[3] ^ 8'h01;
    rx_send(fr, 1'b0, 1'b0);
    wait_drain();
    chk("rx_err_after_bad", rx_err, err_exp);
    fr = '{8'h31, 8'h32, 8'h33};
    rx_send(fr, 1'b0, 1'b1);

    bp = 1'b1;
    for (int f = 0; f < 10; f++) begin
      logic [31:0] c;
      fr = {};
      repeat ($urandom_range(0, 12)) fr.push_back(8'($urandom));
      c = 32'hFFFFFFFF;
      foreach (fr[i]) c = crc_upd(c, fr[i]);
      if (f % 3 != 2) for (int i = 0; i < 4; i++) fr.push_back(8'((~c) >> (8 * i)));
      if (fr.size() == 0) fr.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        int idx;
        idx = $urandom_range(0, fr.size() - 1);
        fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(0, 7));
      end
      st = rx_model(fr);
      rx_send(fr, st[1], st[0]);
    end
    wait_drain();
    bp = 1'b0;
    chk("rx_err_cnt", rx_err, err_exp);

    // reset while TX FCS beat 2 is still pending
    foreach (msg[i]) exp8_q.push_back({1'b0, msg[i]});
    foreach (fcs8[i]) exp8_q.push_back({i == 3, fcs8[i]});
    tx_drive(0, msg);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    exp8_q.delete();
    err_exp = '0;
    @(negedge clk);
    chk("midfcs_rst_valid", {t8_ov, rx_sv, rx_err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    foreach (msg[i]) exp8_q.push_back({1'b0, msg[i]});
    foreach (fcs8[i]) exp8_q.push_back({i == 3, fcs8[i]});
    tx_drive(0, msg);
    wait_drain();

`ifdef MII_NET_FCS_ERRCNT_EN
    fr = '{8'h31, 8'h32, 8'h33};
    rx_send(fr, 1'b0, 1'b1);
    for (int f = 0; f < 32'h10001; f++) begin
      fr = {};
      fr.push_back(8'($urandom));
      rx_send(fr, 1'b0, 1'b1);
    end
    wait_drain();
    chk("rx_err_saturate", rx_err, 16'hFFFF);
`endif
    chk("tx_err_zero", {t8_err, t4_err}, 0);
    chk("rx_err_final", rx_err, err_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
